// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcodes, FSM encoding and the single-cycle ALU evaluator.
package alu_pkg;
   localparam int OP_W = 4;
   localparam int RES_W = 8;
   typedef enum logic [2:0] {
      OP_ADD = 3'b000, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MUL, OP_RSV
   } opcode_t;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;
   typedef struct packed {
      logic [RES_W-1:0] result;
      logic             carry;
   } alu_out_t;
   // MUL and the reserved opcode evaluate to zero here; MUL comes from mul4_seq.
   function automatic alu_out_t alu_eval(input opcode_t op, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
      alu_out_t r;
      logic [OP_W:0] sum, diff;
      sum = {1'b0, a} + {1'b0, b};
      diff = {1'b0, a} - {1'b0, b};
      r = '0;
      case (op)
         OP_ADD: r = '{{3'b0, sum}, sum[OP_W]};
         OP_SUB: r = '{{4'b0, diff[OP_W-1:0]}, diff[OP_W]};
         OP_AND: r.result = {4'b0, a & b};
         OP_OR:  r.result = {4'b0, a | b};
         OP_XOR: r.result = {4'b0, a ^ b};
         OP_NOT: r.result = {4'b0, ~a};
         default: r = '0;
      endcase
      return r;
   endfunction
endpackage

// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: operand/request and result/status bundle of the ALU stage.
interface alu_exec_stage_if;
   import alu_pkg::*;
   logic [OP_W-1:0]  op_a;
   logic [OP_W-1:0]  op_b;
   logic [2:0]       opcode;
   logic             start;
   logic [RES_W-1:0] result;
   logic             carry;
   logic             zero;
   logic             err;
   logic             busy;
   logic             done;
   modport master (output op_a, op_b, opcode, start, input result, carry, zero, err, busy, done);
   modport slave  (input op_a, op_b, opcode, start, output result, carry, zero, err, busy, done);
endinterface

// File: rtl/mul4_seq.sv
// mul4_seq: 4-step shift-add multiplier; product shows the accumulator after the current step.
module mul4_seq
   import alu_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   output logic [RES_W-1:0] product,
   output logic             last
);
   logic [RES_W-1:0] acc, mcand;
   logic [OP_W-1:0]  mplier;
   logic [1:0]       cnt;
   always_comb product = acc + (mplier[0] ? mcand : '0);
   always_comb last = cnt == 2'd3;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc <= '0;
         mcand <= '0;
         mplier <= '0;
         cnt <= '0;
      end else if (load) begin
         acc <= '0;
         mcand <= {{(RES_W-OP_W){1'b0}}, a};
         mplier <= b;
         cnt <= '0;
      end else if (step) begin
         acc <= product;
         mcand <= mcand << 1;
         mplier <= mplier >> 1;
         cnt <= cnt + 2'd1;
      end
   end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: IDLE/EXEC/MUL/DONE sequenced ALU with registered result and flags.
module alu_exec_stage
   import alu_pkg::*;
(
   input logic clock,
   input logic reset,
   alu_exec_stage_if.slave bus
);
   state_t           state, nxt;
   opcode_t          op_q;
   logic [OP_W-1:0]  a_q, b_q;
   logic             accept, mul_step, mul_last, fin;
   logic [RES_W-1:0] product, res_n;
   alu_out_t         ex;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else state <= nxt;
   end
   always_comb begin
      nxt = state == S_IDLE ? (bus.start ? (opcode_t'(bus.opcode) == OP_MUL ? S_MUL : S_EXEC) : S_IDLE) :
            state == S_EXEC ? S_DONE :
            state == S_MUL  ? (mul_last ? S_DONE : S_MUL) : S_IDLE;
   end
   always_comb begin
      bus.busy = state != S_IDLE;
      bus.done = state == S_DONE;
      accept = state == S_IDLE && bus.start;
      mul_step = state == S_MUL;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
         op_q <= OP_ADD;
      end else if (accept) begin
         a_q <= bus.op_a;
         b_q <= bus.op_b;
         op_q <= opcode_t'(bus.opcode);
      end
   end
   mul4_seq u_mul (
      .clock(clock), .reset(reset), .load(accept), .step(mul_step),
      .a(bus.op_a), .b(bus.op_b), .product(product), .last(mul_last)
   );
   // Flags and result move only on entry to DONE and hold until the next completion.
   always_comb begin
      ex = alu_eval(op_q, a_q, b_q);
      fin = state == S_EXEC || (state == S_MUL && mul_last);
      res_n = state == S_MUL ? product : ex.result;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.result <= '0;
         bus.carry <= 1'b0;
         bus.zero <= 1'b0;
         bus.err <= 1'b0;
      end else if (fin) begin
         bus.result <= res_n;
         bus.carry <= state == S_EXEC && ex.carry;
         bus.zero <= res_n == '0;
         bus.err <= state == S_EXEC && op_q == OP_RSV;
      end
   end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed scenario tasks with hand-computed expectations for alu_exec_stage.
module tb_alu_exec_stage;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int n_cmp = 0;
   int n_bad = 0;
   alu_exec_stage_if bus ();
   alu_exec_stage dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issues one op and returns after done is seen (or the bound expires) with its latency.
   task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, output int lat);
      bus.op_a = a;
      bus.op_b = b;
      bus.opcode = op;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if ({bus.result, bus.carry, bus.zero, bus.err, bus.busy, bus.done} !== 13'h0) begin
         $display("FAIL reset_state got=%h want=0", {bus.result, bus.carry, bus.zero, bus.err, bus.busy, bus.done});
         n_bad++;
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_add();
      int lat;
      issue(4'b1010, 4'b0101, 3'b000, lat);
      n_cmp++;
      if (lat !== 2) begin $display("FAIL add_latency got=%0d want=2", lat); n_bad++; end
      n_cmp++;
      if ({bus.result, bus.carry, bus.zero, bus.busy} !== {8'h0F, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL add_result got=%h c=%b z=%b busy=%b want=0f c=0 z=0 busy=1", bus.result, bus.carry, bus.zero, bus.busy);
         n_bad++;
      end
      tick();
      n_cmp++;
      if ({bus.done, bus.busy, bus.result} !== {1'b0, 1'b0, 8'h0F}) begin
         $display("FAIL add_after_done got done=%b busy=%b res=%h want 0 0 0f", bus.done, bus.busy, bus.result);
         n_bad++;
      end
      issue(4'b1111, 4'b1001, 3'b000, lat);
      n_cmp++;
      if ({bus.result, bus.carry} !== {8'h18, 1'b1}) begin
         $display("FAIL add_overflow got=%h c=%b want=18 c=1", bus.result, bus.carry);
         n_bad++;
      end
      tick();
   endtask

   task automatic test_sub();
      int lat;
      issue(4'b0001, 4'b1000, 3'b001, lat);
      n_cmp++;
      if ({bus.result, bus.carry, lat} !== {8'h09, 1'b1, 32'd2}) begin
         $display("FAIL sub_borrow got=%h c=%b lat=%0d want=09 c=1 lat=2", bus.result, bus.carry, lat);
         n_bad++;
      end
      tick();
      issue(4'b1001, 4'b0011, 3'b001, lat);
      n_cmp++;
      if ({bus.result, bus.carry} !== {8'h06, 1'b0}) begin
         $display("FAIL sub_plain got=%h c=%b want=06 c=0", bus.result, bus.carry);
         n_bad++;
      end
      tick();
   endtask

   task automatic test_logic();
      int lat;
      logic [2:0]  ops [4] = '{3'b010, 3'b011, 3'b100, 3'b101};
      logic [3:0]  as  [4] = '{4'hC, 4'hC, 4'hA, 4'h3};
      logic [3:0]  bs  [4] = '{4'h3, 4'h3, 4'hF, 4'h9};
      logic [7:0]  exp [4] = '{8'h00, 8'h0F, 8'h05, 8'h0C};
      for (int i = 0; i < 4; i++) begin
         issue(as[i], bs[i], ops[i], lat);
         n_cmp++;
         if ({bus.result, bus.carry, bus.zero} !== {exp[i], 1'b0, exp[i] == 8'h00}) begin
            $display("FAIL logic_op%0d got=%h c=%b z=%b want=%h c=0 z=%b", ops[i], bus.result, bus.carry, bus.zero, exp[i], exp[i] == 8'h00);
            n_bad++;
         end
         tick();
      end
   endtask

   task automatic test_mul();
      int busy_cnt;
      int lat;
      bus.op_a = 4'hF;
      bus.op_b = 4'hF;
      bus.opcode = 3'b110;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      busy_cnt = 0;
      lat = 0;
      for (int i = 1; i <= 6; i++) begin
         if (bus.busy) busy_cnt++;
         if (bus.done && lat == 0) lat = i;
         if (i < 6) tick();
      end
      n_cmp++;
      if ({busy_cnt, lat} !== {32'd5, 32'd5}) begin
         $display("FAIL mul_timing got busy=%0d done_at=%0d want busy=5 done_at=5", busy_cnt, lat);
         n_bad++;
      end
      n_cmp++;
      if ({bus.result, bus.carry} !== {8'hE1, 1'b0}) begin
         $display("FAIL mul_ff got=%h c=%b want=e1 c=0", bus.result, bus.carry);
         n_bad++;
      end
      issue(4'b1100, 4'b0011, 3'b110, lat);
      n_cmp++;
      if ({bus.result, lat} !== {8'h24, 32'd5}) begin
         $display("FAIL mul_c3 got=%h lat=%0d want=24 lat=5", bus.result, lat);
         n_bad++;
      end
      tick();
   endtask

   task automatic test_reserved();
      int lat;
      issue(4'h5, 4'h6, 3'b111, lat);
      n_cmp++;
      if ({bus.result, bus.carry, bus.zero, bus.err} !== {8'h00, 1'b0, 1'b1, 1'b1}) begin
         $display("FAIL reserved got=%h c=%b z=%b e=%b want=00 c=0 z=1 e=1", bus.result, bus.carry, bus.zero, bus.err);
         n_bad++;
      end
      tick();
      issue(4'h1, 4'h1, 3'b000, lat);
      n_cmp++;
      if ({bus.result, bus.zero, bus.err} !== {8'h02, 1'b0, 1'b0}) begin
         $display("FAIL err_clear got=%h z=%b e=%b want=02 z=0 e=0", bus.result, bus.zero, bus.err);
         n_bad++;
      end
      tick();
   endtask

   task automatic test_busy_ignore();
      int dones;
      bus.op_a = 4'h3;
      bus.op_b = 4'h5;
      bus.opcode = 3'b110;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.op_a = 4'hF;
      bus.opcode = 3'b000;
      bus.start = 1'b1;
      dones = 0;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (bus.done) dones++;
         if (bus.done) begin
            n_cmp++;
            if (bus.result !== 8'h0F) begin
               $display("FAIL busy_ignore_result got=%h want=0f", bus.result);
               n_bad++;
            end
         end
         tick();
      end
      n_cmp++;
      if (dones !== 1) begin $display("FAIL busy_ignore_dones got=%0d want=1", dones); n_bad++; end
   endtask

   task automatic test_back_to_back();
      int lat;
      issue(4'h2, 4'h3, 3'b000, lat);
      bus.op_a = 4'h7;
      bus.opcode = 3'b011;
      bus.start = 1'b1;
      tick();
      n_cmp++;
      if (bus.busy !== 1'b0) begin $display("FAIL done_start_ignored got busy=%b want=0", bus.busy); n_bad++; end
      issue(4'h7, 4'h8, 3'b011, lat);
      n_cmp++;
      if ({bus.result, lat} !== {8'h0F, 32'd2}) begin
         $display("FAIL back_to_back got=%h lat=%0d want=0f lat=2", bus.result, lat);
         n_bad++;
      end
      tick();
   endtask

   task automatic test_reset_mid_mul();
      int dones;
      int lat;
      bus.op_a = 4'hF;
      bus.op_b = 4'hF;
      bus.opcode = 3'b110;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({bus.result, bus.carry, bus.zero, bus.err, bus.busy, bus.done} !== 13'h0) begin
         $display("FAIL reset_mid_mul got=%h want=0", {bus.result, bus.carry, bus.zero, bus.err, bus.busy, bus.done});
         n_bad++;
      end
      tick();
      reset = 1'b0;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.done) dones++;
         tick();
      end
      n_cmp++;
      if (dones !== 0) begin $display("FAIL reset_no_done got=%0d want=0", dones); n_bad++; end
      issue(4'h3, 4'h5, 3'b110, lat);
      n_cmp++;
      if ({bus.result, lat} !== {8'h0F, 32'd5}) begin
         $display("FAIL after_reset_mul got=%h lat=%0d want=0f lat=5", bus.result, lat);
         n_bad++;
      end
      tick();
   endtask

   task automatic test_reset_first_start();
      int lat;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      issue(4'h4, 4'h4, 3'b000, lat);
      n_cmp++;
      if ({bus.result, lat} !== {8'h08, 32'd2}) begin
         $display("FAIL first_start got=%h lat=%0d want=08 lat=2", bus.result, lat);
         n_bad++;
      end
      tick();
   endtask

   initial begin
      bus.op_a = '0;
      bus.op_b = '0;
      bus.opcode = '0;
      bus.start = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_mul();
      test_reserved();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_mul();
      test_reset_first_start();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter: none; operand width fixed at 4 bits, result width 8 bits.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 op_a  input  4  operand A, from the registered four-bit input stage output 1.
REQ-006 op_b  input  4  operand B, from the registered four-bit input stage output 2.
REQ-007 opcode  input  3  operation select.
REQ-008 start  input  1  request; sampled only in IDLE.
REQ-009 result  output  8  registered result, zero-extended for 4-bit ops.
REQ-010 carry  output  1  ADD carry-out / SUB borrow; 0 for all other ops.
REQ-011 zero  output  1  high when result == 0 at completion.
REQ-012 err  output  1  high when completed op was the reserved opcode.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  single-cycle completion pulse.

Function
REQ-015 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 MUL, 111 reserved.
REQ-016 FSM states SHALL be IDLE, EXEC, MUL, DONE.
REQ-017 IDLE with start=1: latch op_a, op_b, opcode; go MUL if opcode=110, else EXEC.
REQ-018 IDLE with start=0: remain IDLE; outputs hold.
REQ-019 EXEC: compute the latched op, register result and flags, go DONE (one cycle).
REQ-020 MUL: 4-step shift-add on latched operands, one partial-product step per cycle, exactly 4 cycles, then DONE.
REQ-021 DONE: done=1 for exactly that cycle, then IDLE.
REQ-022 Latency: start edge to done high = 2 cycles for non-MUL ops, 5 cycles for MUL.
REQ-023 start while busy SHALL be ignored; no queuing; operand/opcode changes while busy SHALL not affect the running op.
REQ-024 ADD: result = {3'b0, a+b (5 bits)}; carry = bit 4 of sum.
REQ-025 SUB: result[3:0] = (a-b) mod 16, result[7:4]=0; carry=1 iff a<b.
REQ-026 AND/OR/XOR/NOT A: bitwise on 4 bits, upper nibble 0, carry 0.
REQ-027 MUL: result = a*b unsigned, full 8 bits; carry 0.
REQ-028 Reserved opcode: result=0, carry=0, zero=1, err=1; err cleared on next completion of a valid op.
REQ-029 result, carry, zero, err SHALL update only on the EXEC-to-DONE or MUL-to-DONE transition and hold until the next completion.
REQ-030 start asserted in the DONE cycle SHALL be ignored; a new op may start the cycle after done.

Reset
REQ-031 Reset SHALL force state IDLE and result=0, carry=0, zero=0, err=0, busy=0, done=0 immediately, independent of clock.
REQ-032 Reset mid-operation (EXEC, MUL, DONE) SHALL abort the op with no done pulse; internal operand/accumulator registers cleared.
REQ-033 After reset deassertion, first start SHALL be accepted on the first rising edge.

Structure
REQ-034 A shared package alu_pkg SHALL hold opcode constants, FSM state encoding, and width constants (4, 8).
REQ-035 The shift-add datapath SHALL be a sub-module mul4_seq (load, step, 8-bit product, 2-bit step counter), controlled by the FSM.
REQ-036 All other ops SHALL be combinational within alu_exec_stage, registered at the output.

Verification
REQ-037 ADD: a=1010, b=0101, start 1 cycle -> 2 cycles later done=1, result=0x0F, carry=0, zero=0.
REQ-038 ADD overflow / SUB borrow: a=1111,b=1001 ADD -> result=0x18, carry=1; a=0001,b=1000 SUB -> result=0x09, carry=1.
REQ-039 MUL: a=1111,b=1111 -> busy for 5 cycles, done on 5th, result=0xE1; a=1100,b=0011 -> 0x24.
REQ-040 Zero/reserved: a=1100,b=0011 AND -> result=0, zero=1; opcode 111 -> err=1, zero=1; next valid op clears err.
REQ-041 Busy ignore: start MUL, change op_a and pulse start at cycle 2 -> single done, result from original operands.
REQ-042 Reset mid-MUL: assert reset in MUL cycle 2 -> outputs zero at once, no done pulse, next start completes normally.
